memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: clk, reset_n; reset_n is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 if_req  in  1  fetch request; held with if_addr stable until if_ready.
REQ-005 if_addr  in  64  fetch byte address.
REQ-006 if_ready  out  1  one-cycle pulse: if_instr valid and request complete.
REQ-007 if_instr  out  32  fetched instruction.
REQ-008 d_req  in  1  data request; held with d_we, d_size, d_addr, d_wdata stable until d_ready.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
REQ-011 d_addr  in  64  data byte address.
REQ-012 d_wdata  in  64  store data, right-aligned.
REQ-013 d_ready  out  1  one-cycle pulse: access complete; d_rdata valid for loads.
REQ-014 d_rdata  out  64  load data, right-aligned, zero-extended.
REQ-015 mem_addr  out  64  byte address to the shared byte-wide memory.
REQ-016 mem_we  out  1  byte write enable.
REQ-017 mem_wdata  out  8  byte write data.
REQ-018 mem_rdata  in  8  byte read data; combinational from mem_addr.

Function
REQ-019 States SHALL be IDLE, IF_XFER, D_XFER, RESP.
REQ-020 IDLE: no request -> stay; only if_req -> IF_XFER; only d_req -> D_XFER; both -> grant the port not granted last (round-robin); the last-grant flag resets to "fetch", so data wins the first tie.
REQ-021 On grant, SHALL latch base address, byte count N (fetch N=4; data N=2^d_size), direction and write data; set byte counter k=0.
REQ-022 XFER states: one byte per cycle; mem_addr = base + k (mod 2^64, wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 allowed); k increments each cycle.
REQ-023 Byte order is big-endian: byte at base+0 is the MSB of the N-byte value.
REQ-024 Reads: each XFER cycle shift accumulator left 8 and insert mem_rdata at [7:0]; accumulator cleared at grant.
REQ-025 Stores: mem_we=1 each D_XFER cycle; mem_wdata = d_wdata bits [8*(N-1-k)+7 : 8*(N-1-k)]; accumulator unused.
REQ-026 After byte k=N-1 -> RESP; RESP lasts exactly one cycle and then returns to IDLE.
REQ-027 In RESP: the granted port's ready = 1; fetch: if_instr <= accumulator[31:0]; data load: d_rdata <= accumulator (zero-extended); store: d_rdata unchanged.
REQ-028 if_instr and d_rdata SHALL hold their value until the next completion on their own port.
REQ-029 Latency: grant cycle + N transfer cycles + RESP; fetch ready 5 cycles after the IDLE cycle that sampled if_req; 8-byte data access 9 cycles.
REQ-030 Outside XFER states: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-031 Requests arriving during a transfer SHALL wait; the arbiter samples only in IDLE.
REQ-032 A request held high in the cycle after RESP SHALL be treated as a new request.
REQ-033 Deassertion of a granted req mid-transfer SHALL be ignored; the transfer completes and ready pulses.
REQ-034 if_ready and d_ready SHALL never be 1 in the same cycle.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, k=0, accumulator=0, last-grant=fetch.
REQ-036 reset_n low SHALL immediately force if_ready=0, d_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, if_instr=0, d_rdata=0.
REQ-037 Reset mid-transfer SHALL abort with no ready pulse and no further memory writes.

Verification
REQ-038 Memory 0x0..0x3 = 13 05 A0 00; if_req, if_addr=0 -> mem_addr 0,1,2,3; if_ready pulse 5 cycles later with if_instr=0x1305A000.
REQ-039 Store d_size=3, d_addr=0x100, d_wdata=0x0102030405060708 -> 8 cycles mem_we=1, bytes 01..08 at 0x100..0x107; d_ready pulse; then 2-byte load at 0x106 -> d_rdata=0x0000000000000708.
REQ-040 if_req and d_req asserted together from reset and held high -> grants D, I, D, I alternate; ready pulses never overlap.
REQ-041 1-byte load at 0xFFFF_FFFF_FFFF_FFFF and 2-byte load at the same address -> mem_addr ...FF then 0x0 (wrap); d_rdata = {byte@FFFF..., byte@0}.
REQ-042 reset_n pulsed low during byte 3 of an 8-byte store -> mem_we drops at once; no d_ready; bytes 0..2 written, 3..7 untouched; next fetch completes normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter between a fetch port and a data port sharing one byte-wide memory.
module memory_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, IF_XFER, D_XFER, RESP} state_t;
  state_t      state;
  logic [2:0]  k, last_k, d_last;
  logic [63:0] acc, wbuf, acc_nxt, d_wsh;
  logic        we, last_d, grant_d;
  assign acc_nxt = {acc[55:0], mem_rdata};
  assign d_last  = 3'((4'd1 << d_size) - 4'd1);
  // store data left-justified so the most significant byte of the N-byte value leaves first
  assign d_wsh   = d_wdata << {~d_last, 3'b000};
  assign grant_d = d_req && (!if_req || !last_d);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      last_k    <= '0;
      acc       <= '0;
      wbuf      <= '0;
      we        <= 1'b0;
      last_d    <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_instr  <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || if_req) begin
            state     <= grant_d ? D_XFER : IF_XFER;
            last_d    <= grant_d;
            last_k    <= grant_d ? d_last : 3'd3;
            we        <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_we    <= grant_d && d_we;
            mem_wdata <= (grant_d && d_we) ? d_wsh[63:56] : 8'h00;
            wbuf      <= d_wsh << 8;
            k         <= '0;
            acc       <= '0;
          end
        end
        IF_XFER, D_XFER: begin
          acc <= acc_nxt;
          k   <= k + 3'd1;
          if (k == last_k) begin
            state     <= RESP;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if_ready  <= state == IF_XFER;
            d_ready   <= state == D_XFER;
            if (state == IF_XFER) if_instr <= acc_nxt[31:0];
            if (state == D_XFER && !we) d_rdata <= acc_nxt;
          end else begin
            mem_addr  <= mem_addr + 64'd1;
            mem_wdata <= we ? wbuf[63:56] : 8'h00;
            wbuf      <= wbuf << 8;
          end
        end
        default: begin
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven and scoreboard checks of memory_arbiter against a byte memory model.
module tb_memory_arbiter;
  logic        clk = 1'b0, reset_n, if_req, if_ready, d_req, d_we, d_ready, mem_we, load_mem;
  logic [1:0]  d_size;
  logic [31:0] if_instr;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [512];
  int          n_tests = 0, n_fail = 0;

  typedef struct {logic is_d; logic we; logic [1:0] size; logic drop; logic [63:0] addr, wdata, exp;} vec_t;
  typedef struct {logic is_d; logic [63:0] exp;} sb_t;
  sb_t  q[$];
  vec_t tv[13];

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_instr(if_instr), .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 512-byte memory aliased on the low address bits; 0xFFFF_FFFF_FFFF_FFFF lands on 0x1FF
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h13; mem[1] <= 8'h05; mem[2] <= 8'hA0; mem[3] <= 8'h00;
      mem[9'h1FF] <= 8'hAB;
      for (int i = 0; i < 8; i++) mem[9'h10 + i] <= 8'(8'h11 * (i + 1));
      for (int i = 0; i < 8; i++) mem[9'h40 + i] <= 8'hEE;
    end else if (mem_we) mem[mem_addr[8:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (if_ready || d_ready)) begin
      sb_t e;
      if (if_ready && d_ready) chk("ready_overlap", 64'(if_ready & d_ready), 64'd0);
      else if (q.size() == 0) chk("unexpected_ready", {62'b0, if_ready, d_ready}, 64'd0);
      else begin
        e = q.pop_front();
        chk("ready_port", 64'(d_ready), 64'(e.is_d));
        if (e.is_d) chk("d_rdata", d_rdata, e.exp);
        else chk("if_instr", 64'(if_instr), e.exp);
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int n = v.is_d ? (1 << v.size) : 4;
    logic [63:0] b;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    q.push_back('{v.is_d, v.exp});
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_addr%0d", id, k), mem_addr, v.addr + 64'(k));
      chk($sformatf("v%0d_we%0d", id, k), 64'(mem_we), 64'(v.is_d & v.we));
      b = v.wdata >> (8 * (n - 1 - k));
      chk($sformatf("v%0d_wdata%0d", id, k), 64'(mem_wdata), (v.is_d && v.we) ? 64'(b[7:0]) : 64'd0);
      chk($sformatf("v%0d_busy%0d", id, k), {62'b0, if_ready, d_ready}, 64'd0);
      if (v.drop) begin if_req = 1'b0; d_req = 1'b0; end
    end
    @(negedge clk);
    chk($sformatf("v%0d_latency", id), {62'b0, if_ready, d_ready}, v.is_d ? 64'd1 : 64'd2);
    chk($sformatf("v%0d_resp_mem", id), {mem_addr[62:0], mem_we} | 64'(mem_wdata), 64'd0);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h1305A000};
    tv[1]  = '{1'b1, 1'b1, 2'd3, 1'b0, 64'h100, 64'h0102030405060708, 64'h11223344};
    tv[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h106, 64'h0, 64'h0708};
    tv[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hAB};
    tv[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hAB13};
    tv[5]  = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h10, 64'h0, 64'h11223344};
    tv[6]  = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 64'h0102030405060708};
    tv[7]  = '{1'b1, 1'b1, 2'd1, 1'b0, 64'h20, 64'hFFFFBEEF, 64'h0102030405060708};
    tv[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h20, 64'h0, 64'hBEEF0000};
    tv[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 64'h12, 64'h0, 64'h33445566};
    tv[10] = '{1'b1, 1'b1, 2'd0, 1'b0, 64'h30, 64'h5A, 64'hBEEF0000};
    tv[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h30, 64'h0, 64'h5A};
    tv[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h100, 64'h0, 64'h01020304};
    reset_n = 1'b0; load_mem = 1'b1;
    if_req = 1'b1; if_addr = 64'h0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 64'h10; d_wdata = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    load_mem = 1'b0;
    // both ports held high from reset: data wins the first tie, then strict alternation
    for (int i = 0; i < 2; i++) begin
      q.push_back('{1'b1, 64'h11223344});
      q.push_back('{1'b0, 64'h1305A000});
    end
    reset_n = 1'b1;
    for (int c = 0; c < 60 && q.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    chk("rr_pending", 64'(q.size()), 64'd0);
    q.delete();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run_vec(i, tv[i]);
    // reset while byte 3 of an 8-byte store is on the bus
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd3; d_addr = 64'h40; d_wdata = 64'hA1A2A3A4A5A6A7A8;
    repeat (4) @(negedge clk);
    chk("abort_addr_b3", mem_addr, 64'h43);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_mem_addr", mem_addr, 64'd0);
    chk("abort_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("abort_d_ready", 64'(d_ready), 64'd0);
    chk("abort_d_rdata", d_rdata, 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abort_byte%0d", i), 64'(mem[9'h40 + i]), i < 3 ? 64'(8'hA1 + i) : 64'hEE);
    run_vec(13, tv[0]);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
